// File: rtl/usb_input_poller.sv
// Polls the USB controller for mouse reports over a toggle handshake and integrates the deltas
// into a clamped cursor with an update strobe; define TOUCH_POLL_EN to also poll the touch panel.
module usb_input_poller #(
    parameter logic [31:0] POLL_INTERVAL = 32'd500000,
    parameter int          SCREEN_W      = 640,
    parameter int          SCREEN_H      = 480,
    parameter logic [31:0] TIMEOUT       = 32'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_valid,
    input  logic        enable,
    output logic        mouse_command,
    input  logic        mouse_response,
    input  logic [31:0] mouse_deltax,
    input  logic [31:0] mouse_deltay,
    input  logic        mouse_button1,
    input  logic        mouse_button2,
    input  logic        mouse_button3,
    output logic        touch_command,
    input  logic        touch_response,
    input  logic [9:0]  touch_x,
    input  logic [8:0]  touch_y,
    input  logic        touch_pressed,
    output logic [9:0]  cursor_x,
    output logic [8:0]  cursor_y,
    output logic [2:0]  buttons,
    output logic        update,
    output logic        timeout
);
    localparam logic signed [33:0] MAX_X = 34'(SCREEN_W - 1);
    localparam logic signed [33:0] MAX_Y = 34'(SCREEN_H - 1);
    localparam logic [9:0]         MID_X = 10'(SCREEN_W / 2);
    localparam logic [8:0]         MID_Y = 9'(SCREEN_H / 2);
`ifdef TOUCH_POLL_EN
    localparam logic [9:0]         MAX_X10 = 10'(SCREEN_W - 1);
    localparam logic [8:0]         MAX_Y9  = 9'(SCREEN_H - 1);
`endif

    typedef enum logic [3:0] {
        IDLE, MREQ, MWAIT, MCAP, UPDATE
`ifdef TOUCH_POLL_EN
        , TREQ, TWAIT, TCAP, TUPD
`endif
    } state_t;

    state_t             state_q;
    logic [31:0]        poll_cnt_q;
    logic [31:0]        wait_cnt_q;
    logic               mouse_cmd_q;
    logic [1:0]         msync_q;
    logic [9:0]         cx_q;
    logic [8:0]         cy_q;
    logic [2:0]         btn_q;
    logic               update_q;
    logic               timeout_q;
    logic signed [33:0] nx_d;
    logic signed [33:0] ny_d;
    logic               wait_hit_d;
`ifdef TOUCH_POLL_EN
    logic               touch_cmd_q;
    logic [1:0]         tsync_q;
`endif

    // 34-bit signed sums cannot overflow even for +/-2^31 deltas, so clamping never sees a wrap.
    assign nx_d = $signed({24'd0, cx_q}) + $signed({{2{mouse_deltax[31]}}, mouse_deltax});
    assign ny_d = $signed({25'd0, cy_q}) + $signed({{2{mouse_deltay[31]}}, mouse_deltay});
    assign wait_hit_d = (32'(wait_cnt_q + 32'd1) >= TIMEOUT);

    function automatic logic signed [33:0] clamp(input logic signed [33:0] v,
                                                 input logic signed [33:0] hi);
        if (v[33])       clamp = '0;
        else if (v > hi) clamp = hi;
        else             clamp = v;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            poll_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            mouse_cmd_q <= 1'b0;
            msync_q     <= '0;
            cx_q        <= MID_X;
            cy_q        <= MID_Y;
            btn_q       <= '0;
            update_q    <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef TOUCH_POLL_EN
            touch_cmd_q <= 1'b0;
            tsync_q     <= '0;
`endif
        end else if (clock_valid) begin
            msync_q  <= {msync_q[0], mouse_response};
`ifdef TOUCH_POLL_EN
            tsync_q  <= {tsync_q[0], touch_response};
`endif
            update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        if (poll_cnt_q == POLL_INTERVAL) begin
                            poll_cnt_q <= '0;
                            state_q    <= MREQ;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 32'd1;
                        end
                    end
                end
                MREQ: begin
                    mouse_cmd_q <= ~mouse_cmd_q;
                    wait_cnt_q  <= '0;
                    state_q     <= MWAIT;
                end
                MWAIT: begin
                    if (msync_q[1] == mouse_cmd_q) begin
                        state_q <= MCAP;
                    end else begin
                        if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 32'd1;
                        if (wait_hit_d)       timeout_q  <= 1'b1;
                    end
                end
                MCAP: begin
                    cx_q     <= 10'(clamp(nx_d, MAX_X));
                    cy_q     <= 9'(clamp(ny_d, MAX_Y));
                    btn_q    <= {mouse_button3, mouse_button2, mouse_button1};
                    update_q <= 1'b1;
                    state_q  <= UPDATE;
                end
                UPDATE: begin
                    timeout_q <= 1'b0;
`ifdef TOUCH_POLL_EN
                    state_q   <= TREQ;
`else
                    state_q   <= IDLE;
`endif
                end
`ifdef TOUCH_POLL_EN
                TREQ: begin
                    touch_cmd_q <= ~touch_cmd_q;
                    wait_cnt_q  <= '0;
                    state_q     <= TWAIT;
                end
                TWAIT: begin
                    if (tsync_q[1] == touch_cmd_q) begin
                        state_q <= TCAP;
                    end else begin
                        if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 32'd1;
                        if (wait_hit_d)       timeout_q  <= 1'b1;
                    end
                end
                TCAP: begin
                    if (touch_pressed) begin
                        cx_q     <= (touch_x > MAX_X10) ? MAX_X10 : touch_x;
                        cy_q     <= (touch_y > MAX_Y9) ? MAX_Y9 : touch_y;
                        btn_q[0] <= 1'b1;
                    end
                    update_q <= 1'b1;
                    state_q  <= TUPD;
                end
                TUPD: begin
                    timeout_q <= 1'b0;
                    state_q   <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mouse_command = mouse_cmd_q;
    assign cursor_x      = cx_q;
    assign cursor_y      = cy_q;
    assign buttons       = btn_q;
    assign timeout       = timeout_q;
    // A held strobe must not be seen twice while the clock enable is low.
    assign update        = update_q & clock_valid;

`ifdef TOUCH_POLL_EN
    assign touch_command = touch_cmd_q;
`else
    logic unused_touch;
    assign unused_touch  = ^{touch_response, touch_x, touch_y, touch_pressed};
    assign touch_command = 1'b0;
`endif
endmodule

// File: tb/tb_usb_input_poller.sv
// Bench for usb_input_poller: echoing responder, scoreboard of expected cursor/buttons per update.
module tb_usb_input_poller;
    localparam logic [31:0] PI = 32'd20;
    localparam logic [31:0] TO = 32'd100;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clock_valid = 1'b1;
    logic        enable = 1'b0;
    logic        mouse_command;
    logic        mouse_response = 1'b0;
    logic [31:0] mouse_deltax = '0;
    logic [31:0] mouse_deltay = '0;
    logic        mouse_button1 = 1'b0;
    logic        mouse_button2 = 1'b0;
    logic        mouse_button3 = 1'b0;
    logic        touch_command;
    logic        touch_response = 1'b0;
    logic [9:0]  touch_x = '0;
    logic [8:0]  touch_y = '0;
    logic        touch_pressed = 1'b0;
    logic [9:0]  cursor_x;
    logic [8:0]  cursor_y;
    logic [2:0]  buttons;
    logic        update;
    logic        timeout;

    usb_input_poller #(
        .POLL_INTERVAL(PI), .SCREEN_W(640), .SCREEN_H(480), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .clock_valid(clock_valid), .enable(enable),
        .mouse_command(mouse_command), .mouse_response(mouse_response),
        .mouse_deltax(mouse_deltax), .mouse_deltay(mouse_deltay),
        .mouse_button1(mouse_button1), .mouse_button2(mouse_button2), .mouse_button3(mouse_button3),
        .touch_command(touch_command), .touch_response(touch_response),
        .touch_x(touch_x), .touch_y(touch_y), .touch_pressed(touch_pressed),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .buttons(buttons),
        .update(update), .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   mx = 320;
    int   my = 240;
    logic [2:0] mb = '0;
    int   cyc = 0;
    int   upd_count = 0;
    int   toggles = 0;
    int   last_upd_cyc = 0;
    int   ack_cyc = 0;
    int   ack_delay = 5;
    int   ack_cnt = 0;
    bit   ack_en = 0;
    bit   cv_toggle = 0;
    logic prev_cmd = 1'b0;

    function automatic int clampi(longint v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return int'(v);
    endfunction

    // Mouse responder: echoes the command after ack_delay cycles and records the expected result.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (!reset) begin
            mouse_response = 1'b0;
            ack_cnt = 0;
        end else if (ack_en && mouse_command !== mouse_response) begin
            if (ack_cnt >= ack_delay) begin
                mouse_response = mouse_command;
                ack_cnt = 0;
                ack_cyc = cyc;
                mx = clampi(longint'(mx) + longint'($signed(mouse_deltax)), 639);
                my = clampi(longint'(my) + longint'($signed(mouse_deltay)), 479);
                mb = {mouse_button3, mouse_button2, mouse_button1};
                sb.push_back('{x: 10'(mx), y: 9'(my), b: mb});
            end else begin
                ack_cnt++;
            end
        end
    end

`ifdef TOUCH_POLL_EN
    int tack_cnt = 0;
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            touch_response = 1'b0;
            tack_cnt = 0;
        end else if (ack_en && touch_command !== touch_response) begin
            if (tack_cnt >= ack_delay) begin
                touch_response = touch_command;
                tack_cnt = 0;
                if (touch_pressed) begin
                    mx = (int'(touch_x) > 639) ? 639 : int'(touch_x);
                    my = (int'(touch_y) > 479) ? 479 : int'(touch_y);
                    mb[0] = 1'b1;
                end
                sb.push_back('{x: 10'(mx), y: 9'(my), b: mb});
            end else begin
                tack_cnt++;
            end
        end
    end
`endif

    always @(posedge clock) begin
        #1;
        if (cv_toggle) clock_valid = ~clock_valid;
    end

    // Monitor: counts command toggles and scores every update pulse.
    always @(negedge clock) begin
        if (!reset) begin
            prev_cmd = 1'b0;
        end else begin
            if (mouse_command !== prev_cmd) toggles++;
            prev_cmd = mouse_command;
            if (update === 1'b1) begin
                upd_count++;
                last_upd_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: got (%0d,%0d,%b) with nothing expected",
                             cursor_x, cursor_y, buttons);
                end else begin
                    e = sb.pop_front();
                    if ({cursor_x, cursor_y, buttons} !== e) begin
                        errors++;
                        $display("FAIL update_value: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                                 cursor_x, cursor_y, buttons, e.x, e.y, e.b);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        enable = 1'b0;
        ack_en = 0;
        reset = 1'b0;
        sb.delete();
        mx = 320; my = 240; mb = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_updates(int n, string tag);
        int start = upd_count;
        int k = 0;
        while (upd_count < start + n && k < 3000) begin
            @(posedge clock);
            k++;
        end
        checks++;
        if (upd_count < start + n) begin
            errors++;
            $display("FAIL %s_wait: got %0d updates expected %0d", tag, upd_count - start, n);
        end
        #1;
    endtask

    task automatic drain(string tag);
        enable = 1'b0;
        repeat (40) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected updates never seen", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        logic [25:0] obs;
        apply_reset();
        #1;
        obs = {mouse_command, touch_command, cursor_x, cursor_y, buttons, update, timeout};
        checks++;
        if (obs !== {1'b0, 1'b0, 10'd320, 9'd240, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs,
                     {1'b0, 1'b0, 10'd320, 9'd240, 3'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_basic();
        int t0;
        apply_reset();
        mouse_deltax = 32'd10;
        mouse_deltay = -32'sd20;
        {mouse_button3, mouse_button2, mouse_button1} = 3'b101;
        ack_delay = 5;
        ack_en = 1;
        t0 = toggles;
        enable = 1'b1;
        wait_updates(1, "basic");
        enable = 1'b0;
        checks++;
        if (cursor_x !== 10'd330 || cursor_y !== 9'd220) begin
            errors++;
            $display("FAIL basic_cursor: got (%0d,%0d) expected (330,220)", cursor_x, cursor_y);
        end
        checks++;
        if (buttons !== 3'b101) begin
            errors++;
            $display("FAIL basic_buttons: got %b expected 101", buttons);
        end
        checks++;
        if (toggles - t0 != 1) begin
            errors++;
            $display("FAIL basic_toggles: got %0d expected 1", toggles - t0);
        end
        checks++;
        if (last_upd_cyc - ack_cyc != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles expected 4", last_upd_cyc - ack_cyc);
        end
        drain("basic");
        checks++;
        if (toggles - t0 != 1) begin
            errors++;
            $display("FAIL basic_hold: got %0d toggles expected 1", toggles - t0);
        end
    endtask

    task automatic test_clamp();
        apply_reset();
        {mouse_button3, mouse_button2, mouse_button1} = 3'b010;
        ack_en = 1;
        mouse_deltax = 32'd1000;
        mouse_deltay = 32'd1000;
        enable = 1'b1;
        wait_updates(1, "clamp_hi");
        enable = 1'b0;
        checks++;
        if (cursor_x !== 10'd639 || cursor_y !== 9'd479) begin
            errors++;
            $display("FAIL clamp_hi: got (%0d,%0d) expected (639,479)", cursor_x, cursor_y);
        end
        mouse_deltax = 32'h8000_0000;
        mouse_deltay = 32'h8000_0000;
        enable = 1'b1;
        wait_updates(1, "clamp_lo");
        enable = 1'b0;
        checks++;
        if (cursor_x !== 10'd0 || cursor_y !== 9'd0) begin
            errors++;
            $display("FAIL clamp_lo: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y);
        end
        mouse_deltax = 32'h7FFF_FFFF;
        mouse_deltay = 32'h7FFF_FFFF;
        enable = 1'b1;
        wait_updates(1, "clamp_max");
        enable = 1'b0;
        checks++;
        if (cursor_x !== 10'd639 || cursor_y !== 9'd479) begin
            errors++;
            $display("FAIL clamp_max: got (%0d,%0d) expected (639,479)", cursor_x, cursor_y);
        end
        drain("clamp");
    endtask

    task automatic test_timeout();
        int t0;
        int k = 0;
        apply_reset();
        mouse_deltax = 32'd3;
        mouse_deltay = 32'd4;
        t0 = toggles;
        enable = 1'b1;
        while (toggles == t0 && k < 200) begin
            @(posedge clock);
            k++;
        end
        checks++;
        if (toggles == t0) begin
            errors++;
            $display("FAIL timeout_request: got no toggle expected one");
        end
        repeat (50) @(posedge clock);
        #1;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got %b expected 0", timeout);
        end
        repeat (60) @(posedge clock);
        #1;
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: got %b expected 1", timeout);
        end
        enable = 1'b0;
        repeat (50) @(posedge clock);
        checks++;
        if (toggles - t0 != 1 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: got toggles=%0d timeout=%b expected 1/1", toggles - t0, timeout);
        end
        ack_en = 1;
        wait_updates(1, "timeout_late");
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b expected 0", timeout);
        end
        drain("timeout");
    endtask

    task automatic test_reset_mid();
        int t0;
        int k = 0;
        int n = 0;
        logic [25:0] obs;
        apply_reset();
        mouse_deltax = 32'd5;
        mouse_deltay = 32'd5;
        t0 = toggles;
        enable = 1'b1;
        while (toggles == t0 && k < 200) begin
            @(posedge clock);
            k++;
        end
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        obs = {mouse_command, touch_command, cursor_x, cursor_y, buttons, update, timeout};
        checks++;
        if (obs !== {1'b0, 1'b0, 10'd320, 9'd240, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_state: got %h expected %h", obs,
                     {1'b0, 1'b0, 10'd320, 9'd240, 3'd0, 1'b0, 1'b0});
        end
        sb.delete();
        mx = 320; my = 240; mb = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        while (n < 100) begin
            @(posedge clock);
            n++;
            #2;
            if (mouse_command !== 1'b0) break;
        end
        checks++;
        if (n != int'(PI) + 2) begin
            errors++;
            $display("FAIL reset_mid_interval: got %0d cycles expected %0d", n, int'(PI) + 2);
        end
        ack_en = 1;
        wait_updates(1, "reset_mid");
        enable = 1'b0;
        checks++;
        if (cursor_x !== 10'd325 || cursor_y !== 9'd245) begin
            errors++;
            $display("FAIL reset_mid_cursor: got (%0d,%0d) expected (325,245)", cursor_x, cursor_y);
        end
        drain("reset_mid");
    endtask

    task automatic test_clock_valid();
        int n = 0;
        int u0;
        enable = 1'b0;
        ack_en = 0;
        reset = 1'b0;
        sb.delete();
        mx = 320; my = 240; mb = '0;
        mouse_deltax = -32'sd7;
        mouse_deltay = 32'd3;
        {mouse_button3, mouse_button2, mouse_button1} = 3'b100;
        repeat (3) @(posedge clock);
        @(negedge clock);
        enable = 1'b1;
        ack_en = 1;
        clock_valid = 1'b1;
        u0 = upd_count;
        reset = 1'b1;
        cv_toggle = 1;
        while (n < 200) begin
            @(posedge clock);
            n++;
            #2;
            if (mouse_command !== 1'b0) break;
        end
        checks++;
        if (n != 2 * int'(PI) + 3) begin
            errors++;
            $display("FAIL cv_interval: got %0d cycles expected %0d", n, 2 * int'(PI) + 3);
        end
        wait_updates(1, "cv");
        enable = 1'b0;
        checks++;
        if (cursor_x !== 10'd313 || cursor_y !== 9'd243 || buttons !== 3'b100) begin
            errors++;
            $display("FAIL cv_result: got (%0d,%0d,%b) expected (313,243,100)", cursor_x, cursor_y, buttons);
        end
        cv_toggle = 0;
        @(posedge clock);
        #2;
        clock_valid = 1'b1;
        drain("cv");
        checks++;
        if (upd_count - u0 != 1) begin
            errors++;
            $display("FAIL cv_pulses: got %0d expected 1", upd_count - u0);
        end
    endtask

    task automatic test_touch();
        int u0;
        apply_reset();
        mouse_deltax = '0;
        mouse_deltay = '0;
        {mouse_button3, mouse_button2, mouse_button1} = 3'b000;
        touch_x = 10'd700;
        touch_y = 9'd100;
        touch_pressed = 1'b1;
        ack_en = 1;
        u0 = upd_count;
        enable = 1'b1;
`ifdef TOUCH_POLL_EN
        wait_updates(2, "touch");
        enable = 1'b0;
        checks++;
        if (cursor_x !== 10'd639 || cursor_y !== 9'd100 || buttons[0] !== 1'b1) begin
            errors++;
            $display("FAIL touch_cursor: got (%0d,%0d,%b) expected (639,100,xx1)", cursor_x, cursor_y, buttons);
        end
        drain("touch");
        checks++;
        if (upd_count - u0 != 2) begin
            errors++;
            $display("FAIL touch_pulses: got %0d expected 2", upd_count - u0);
        end
`else
        wait_updates(1, "touch_absent");
        enable = 1'b0;
        checks++;
        if (touch_command !== 1'b0 || cursor_x !== 10'd320 || buttons !== 3'b000) begin
            errors++;
            $display("FAIL touch_absent: got cmd=%b x=%0d b=%b expected 0/320/000",
                     touch_command, cursor_x, buttons);
        end
        drain("touch_absent");
        checks++;
        if (upd_count - u0 != 1) begin
            errors++;
            $display("FAIL touch_absent_pulses: got %0d expected 1", upd_count - u0);
        end
`endif
        touch_pressed = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_timeout();
        test_reset_mid();
        test_clock_valid();
        test_touch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
